qtree_search_top: RTL and testbench
===================================

QTREE_SEARCH_TOP -- requirements
Module: qtree_search_top

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning number of tree levels / pipeline stages (>=1).
REQ-002 SHALL have parameter D_WIDTH, default 16, meaning key and lookup data width.
REQ-003 SHALL have parameter B_LOG2, default 2, meaning log2 of branching factor (2 gives a quadtree); K = 2^B_LOG2 - 1 keys per node.
REQ-004 SHALL have: clk_i  in  1  the single clock.
REQ-005 SHALL have: rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have: lookup_valid_i  in  1  lookup request.
REQ-007 SHALL have: lookup_ready_o  out  1  request accepted when valid and ready are both high.
REQ-008 SHALL have: lookup_data_i  in  D_WIDTH  search value.
REQ-009 SHALL have: res_valid_o  out  1  result valid.
REQ-010 SHALL have: res_ready_i  in  1  result consumed when valid and ready are both high.
REQ-011 SHALL have: res_leaf_o  out  B_LOG2*STAGES  leaf index, stage 0 child in the MSBs.
REQ-012 SHALL have: res_match_o  out  1  an exact key equality was hit on the path.
REQ-013 SHALL have: res_data_o  out  D_WIDTH  echo of the searched value.
REQ-014 SHALL have: ctrl_wr_en_i  in  1  key-write strobe.
REQ-015 SHALL have: ctrl_wr_stage_i, ctrl_wr_addr_i, ctrl_wr_idx_i, ctrl_wr_key_i  in  max(1,$clog2(STAGES)), max(1,B_LOG2*(STAGES-1)), B_LOG2, D_WIDTH  target stage, node, key slot, key value.
REQ-016 SHALL have: ctrl_err_o  out  1  one-cycle pulse for a rejected write.
REQ-017 SHALL have: lookup_cnt_o  out  32  completed-result counter.

Function
REQ-018 Stage s SHALL hold 2^(B_LOG2*s) nodes of K keys each; a lookup at node a SHALL select child c = count of node keys <= data (unsigned) and pass address {a,c} to stage s+1.
REQ-019 Match flag SHALL be sticky along the path: set if any compared key equals data at any stage.
REQ-020 Each stage SHALL add exactly one register; a request accepted at cycle N SHALL present res_valid_o at N+STAGES absent stalls.
REQ-021 Stall = res_valid_o && !res_ready_i; while stalled every stage register SHALL hold, and lookup_ready_o SHALL equal !stall.
REQ-022 Outputs SHALL remain stable while res_valid_o is high and res_ready_i is low.
REQ-023 Bubbles SHALL propagate: invalid slots advance like valid ones when not stalled, giving full throughput of one result per cycle.
REQ-024 Key writes SHALL be accepted every cycle regardless of stall and take effect on the next edge; a lookup reading the same key in the write cycle SHALL use the old value.
REQ-025 A write with stage >= STAGES, node address >= 2^(B_LOG2*stage), or idx == 2^B_LOG2-1 SHALL be ignored and SHALL pulse ctrl_err_o the following cycle.
REQ-026 lookup_cnt_o SHALL increment on each res_valid_o && res_ready_i and saturate at 2^32-1.
REQ-027 Key sortedness SHALL NOT be checked; with unsorted keys the result is still c = count of keys <= data.

Reset
REQ-028 On rst_n_i low, all stage valid bits, res_valid_o, ctrl_err_o and lookup_cnt_o SHALL clear to 0 immediately; res_leaf_o, res_match_o and res_data_o SHALL be 0.
REQ-029 Reset SHALL set every key to all-ones, and SHALL discard in-flight lookups with no result emitted.
REQ-030 lookup_ready_o SHALL be 1 during and after reset.

Structure
REQ-031 Package qtree_pkg SHALL hold the default parameters and the stage-payload struct (valid, addr, data, match) plus width helper functions.
REQ-032 One sub-module, qtree_search_stage, SHALL implement a stage: key storage, write decode, compare, and pipeline register; the top SHALL generate STAGES instances.

Verification
REQ-033 After reset, lookup 0x1234 -> leaf 0, match 0, 5 cycles later; lookup 0xFFFF -> leaf 0x3FF, match 1.
REQ-034 STAGES=2: write stage0 keys {0x100,0x200,0x300}, then lookup 0x250 -> stage0 child 2; stage1 node 2 at reset gives leaf 0x8, match 0.
REQ-035 Back-to-back 8 lookups, res_ready_i low for 3 cycles mid-stream -> 8 results in order, none lost or duplicated, and outputs are held during the stall.
REQ-036 Write stage0 idx0 = 0x0010 in the same cycle as a lookup of 0x0010 -> that lookup sees 0xFFFF (child 0, no match); the next lookup gets child 1, match 1.
REQ-037 Write stage=7 (STAGES=5), or idx=3 -> no key change, ctrl_err_o high for exactly one cycle.
REQ-038 Assert rst_n_i with 4 lookups in flight -> no res_valid_o, lookup_cnt_o=0, and keys are back to 0xFFFF.

Source files
------------

// File: rtl/qtree_pkg.sv
// rtl/qtree_pkg.sv - shared defaults, payload type and width helpers for the search tree
package qtree_pkg;
    localparam int DEF_STAGES  = 5;
    localparam int DEF_D_WIDTH = 16;
    localparam int DEF_B_LOG2  = 2;

    // Final-stage payload for the default configuration.
    typedef struct packed {
        logic                             valid;
        logic [DEF_B_LOG2*DEF_STAGES-1:0] addr;
        logic [DEF_D_WIDTH-1:0]           data;
        logic                             match;
    } stage_payload_t;

    function automatic int stage_sel_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    function automatic int wr_addr_w(input int stages, input int b_log2);
        return (stages > 1) ? b_log2 * (stages - 1) : 1;
    endfunction

    function automatic int node_w(input int stage, input int b_log2);
        return (stage > 0) ? b_log2 * stage : 1;
    endfunction
endpackage

// File: rtl/qtree_search_stage.sv
// rtl/qtree_search_stage.sv - one tree level: key table, write decode, child select and pipeline register
module qtree_search_stage
    import qtree_pkg::*;
#(
    parameter int STAGE   = 0,
    parameter int STAGES  = DEF_STAGES,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int B_LOG2  = DEF_B_LOG2,
    parameter int SEL_W   = stage_sel_w(STAGES),
    parameter int WADDR_W = wr_addr_w(STAGES, B_LOG2),
    parameter int AW_IN   = node_w(STAGE, B_LOG2),
    parameter int AW_OUT  = B_LOG2 * (STAGE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_stage,
    input  logic [WADDR_W-1:0] wr_addr,
    input  logic [B_LOG2-1:0]  wr_idx,
    input  logic [D_WIDTH-1:0] wr_key,
    output logic               wr_hit,
    input  logic               req_valid,
    input  logic [AW_IN-1:0]   req_addr,
    input  logic [D_WIDTH-1:0] req_data,
    input  logic               req_match,
    output logic               pay_valid,
    output logic [AW_OUT-1:0]  pay_addr,
    output logic [D_WIDTH-1:0] pay_data,
    output logic               pay_match
);
    localparam int NODES = 1 << (B_LOG2 * STAGE);
    localparam int K     = (1 << B_LOG2) - 1;

    logic [D_WIDTH-1:0] keys [NODES][K];
    logic [AW_IN-1:0]   node;
    logic [AW_IN-1:0]   wr_node;
    logic [AW_OUT-1:0]  next_addr;
    logic [B_LOG2-1:0]  child;
    logic               key_eq;

    assign wr_node = wr_addr[AW_IN-1:0];
    assign wr_hit  = wr_en && (wr_stage == SEL_W'(STAGE))
                   && ((wr_addr >> (B_LOG2 * STAGE)) == '0)
                   && (wr_idx != B_LOG2'(K));

    if (STAGE == 0) begin : g_root
        logic unused_addr;
        assign unused_addr = ^req_addr;
        assign node        = '0;
        assign next_addr   = child;
    end else begin : g_inner
        assign node      = req_addr;
        assign next_addr = {req_addr, child};
    end

    // Keys are not assumed sorted, so the child is a plain count of keys <= data.
    always_comb begin
        child  = '0;
        key_eq = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (keys[node][j] <= req_data) child = child + B_LOG2'(1);
            if (keys[node][j] == req_data) key_eq = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                for (int j = 0; j < K; j++) begin
                    keys[n][j] <= '1;
                end
            end
        end else if (wr_hit) begin
            keys[wr_node][wr_idx] <= wr_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_valid <= 1'b0;
            pay_addr  <= '0;
            pay_data  <= '0;
            pay_match <= 1'b0;
        end else if (!hold) begin
            pay_valid <= req_valid;
            pay_addr  <= next_addr;
            pay_data  <= req_data;
            pay_match <= req_match | key_eq;
        end
    end
endmodule

// File: rtl/qtree_search_top.sv
// rtl/qtree_search_top.sv - pipelined B-ary search tree lookup with runtime key writes
module qtree_search_top
    import qtree_pkg::*;
#(
    parameter int STAGES  = DEF_STAGES,
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int B_LOG2  = DEF_B_LOG2
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              lookup_valid_i,
    output logic                              lookup_ready_o,
    input  logic [D_WIDTH-1:0]                lookup_data_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic [B_LOG2*STAGES-1:0]          res_leaf_o,
    output logic                              res_match_o,
    output logic [D_WIDTH-1:0]                res_data_o,
    input  logic                              ctrl_wr_en_i,
    input  logic [stage_sel_w(STAGES)-1:0]    ctrl_wr_stage_i,
    input  logic [wr_addr_w(STAGES,B_LOG2)-1:0] ctrl_wr_addr_i,
    input  logic [B_LOG2-1:0]                 ctrl_wr_idx_i,
    input  logic [D_WIDTH-1:0]                ctrl_wr_key_i,
    output logic                              ctrl_err_o,
    output logic [31:0]                       lookup_cnt_o
);
    logic              stall;
    logic [STAGES-1:0] wr_hit;

    assign stall          = res_valid_o && !res_ready_i;
    assign lookup_ready_o = !stall;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic                         req_valid;
        logic [node_w(s, B_LOG2)-1:0] req_addr;
        logic [D_WIDTH-1:0]           req_data;
        logic                         req_match;
        logic                         pay_valid;
        logic [B_LOG2*(s+1)-1:0]      pay_addr;
        logic [D_WIDTH-1:0]           pay_data;
        logic                         pay_match;

        if (s == 0) begin : g_head
            assign req_valid = lookup_valid_i;
            assign req_addr  = '0;
            assign req_data  = lookup_data_i;
            assign req_match = 1'b0;
        end else begin : g_link
            assign req_valid = g_stage[s-1].pay_valid;
            assign req_addr  = g_stage[s-1].pay_addr;
            assign req_data  = g_stage[s-1].pay_data;
            assign req_match = g_stage[s-1].pay_match;
        end

        qtree_search_stage #(
            .STAGE   (s),
            .STAGES  (STAGES),
            .D_WIDTH (D_WIDTH),
            .B_LOG2  (B_LOG2)
        ) u_stage (
            .clk       (clk_i),
            .rst_n     (rst_n_i),
            .hold      (stall),
            .wr_en     (ctrl_wr_en_i),
            .wr_stage  (ctrl_wr_stage_i),
            .wr_addr   (ctrl_wr_addr_i),
            .wr_idx    (ctrl_wr_idx_i),
            .wr_key    (ctrl_wr_key_i),
            .wr_hit    (wr_hit[s]),
            .req_valid (req_valid),
            .req_addr  (req_addr),
            .req_data  (req_data),
            .req_match (req_match),
            .pay_valid (pay_valid),
            .pay_addr  (pay_addr),
            .pay_data  (pay_data),
            .pay_match (pay_match)
        );
    end

    assign res_valid_o = g_stage[STAGES-1].pay_valid;
    assign res_leaf_o  = g_stage[STAGES-1].pay_addr;
    assign res_data_o  = g_stage[STAGES-1].pay_data;
    assign res_match_o = g_stage[STAGES-1].pay_match;

    // A write no stage claims was out of range somewhere; flag it one cycle later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_err_o   <= 1'b0;
            lookup_cnt_o <= '0;
        end else begin
            ctrl_err_o <= ctrl_wr_en_i && !(|wr_hit);
            if (res_valid_o && res_ready_i && (lookup_cnt_o != '1)) begin
                lookup_cnt_o <= lookup_cnt_o + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_qtree_search_top.sv
// tb/tb_qtree_search_top.sv - directed self-checking bench for qtree_search_top
module tb_qtree_search_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        lookup_valid, lookup_ready, res_valid, res_ready, res_match, err;
    logic [15:0] lookup_data, res_data, wr_key;
    logic [9:0]  res_leaf;
    logic        wr_en;
    logic [2:0]  wr_stage;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_idx;
    logic [31:0] cnt;

    logic        s2_valid, s2_ready, s2_res_valid, s2_res_ready, s2_match, s2_err, s2_wr_en;
    logic [15:0] s2_data, s2_res_data, s2_wr_key;
    logic [3:0]  s2_leaf;
    logic [0:0]  s2_wr_stage;
    logic [1:0]  s2_wr_addr, s2_wr_idx;
    logic [31:0] s2_cnt;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int sent, got, sawv;
    logic held, fire, h_match;
    logic [9:0]  h_leaf;
    logic [15:0] h_data;

    logic [15:0] sv_data  [8] = '{16'h0005, 16'h0010, 16'h0100, 16'h0200, 16'h0300, 16'hFFFF, 16'h0011, 16'h000F};
    logic [9:0]  sv_leaf  [8] = '{10'h000, 10'h101, 10'h101, 10'h101, 10'h101, 10'h3FF, 10'h101, 10'h000};
    logic        sv_match [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    qtree_search_top dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready), .lookup_data_i(lookup_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_leaf_o(res_leaf),
        .res_match_o(res_match), .res_data_o(res_data),
        .ctrl_wr_en_i(wr_en), .ctrl_wr_stage_i(wr_stage), .ctrl_wr_addr_i(wr_addr),
        .ctrl_wr_idx_i(wr_idx), .ctrl_wr_key_i(wr_key), .ctrl_err_o(err), .lookup_cnt_o(cnt)
    );

    qtree_search_top #(.STAGES(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .lookup_valid_i(s2_valid), .lookup_ready_o(s2_ready), .lookup_data_i(s2_data),
        .res_valid_o(s2_res_valid), .res_ready_i(s2_res_ready), .res_leaf_o(s2_leaf),
        .res_match_o(s2_match), .res_data_o(s2_res_data),
        .ctrl_wr_en_i(s2_wr_en), .ctrl_wr_stage_i(s2_wr_stage), .ctrl_wr_addr_i(s2_wr_addr),
        .ctrl_wr_idx_i(s2_wr_idx), .ctrl_wr_key_i(s2_wr_key), .ctrl_err_o(s2_err), .lookup_cnt_o(s2_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] d);
        lookup_valid = 1'b1;
        lookup_data  = d;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input logic [9:0] leaf, input logic m, input logic [15:0] d);
        int lat;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_leaf"}, 32'(res_leaf), 32'(leaf));
        check({tag, "_match"}, 32'(res_match), 32'(m));
        check({tag, "_data"}, 32'(res_data), 32'(d));
        step();
    endtask

    task automatic bad_write(input string tag, input logic [2:0] st, input logic [7:0] ad, input logic [1:0] ix);
        wr_en = 1'b1; wr_stage = st; wr_addr = ad; wr_idx = ix; wr_key = 16'h0000;
        step();
        wr_en = 1'b0;
        check({tag, "_err_pulse"}, 32'(err), 32'd1);
        step();
        check({tag, "_err_clear"}, 32'(err), 32'd0);
    endtask

    task automatic s2_lookup(input string tag, input logic [15:0] d, input logic [3:0] leaf, input logic m);
        int lat;
        s2_valid = 1'b1;
        s2_data  = d;
        step();
        s2_valid = 1'b0;
        lat = 1;
        while (s2_res_valid !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_leaf"}, 32'(s2_leaf), 32'(leaf));
        check({tag, "_match"}, 32'(s2_match), 32'(m));
        check({tag, "_data"}, 32'(s2_res_data), 32'(d));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; lookup_valid = 1'b0; lookup_data = '0; res_ready = 1'b1;
        wr_en = 1'b0; wr_stage = '0; wr_addr = '0; wr_idx = '0; wr_key = '0;
        s2_valid = 1'b0; s2_data = '0; s2_res_ready = 1'b1;
        s2_wr_en = 1'b0; s2_wr_stage = '0; s2_wr_addr = '0; s2_wr_idx = '0; s2_wr_key = '0;
        #2;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_ready", 32'(lookup_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", cnt, 32'd0);
        check("rst_leaf", 32'(res_leaf), 32'd0);
        check("rst_match", 32'(res_match), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        issue(16'h1234);
        wait_res("lk1234", 10'h000, 1'b0, 16'h1234);
        issue(16'hFFFF);
        wait_res("lkffff", 10'h3FF, 1'b1, 16'hFFFF);
        check("cnt_after_two", cnt, 32'd2);

        wr_en = 1'b1; wr_stage = 3'd0; wr_addr = 8'd0; wr_idx = 2'd0; wr_key = 16'h0010;
        lookup_valid = 1'b1; lookup_data = 16'h0010;
        step();
        wr_en = 1'b0; lookup_valid = 1'b0;
        check("good_write_no_err", 32'(err), 32'd0);
        wait_res("same_cycle_old_key", 10'h000, 1'b0, 16'h0010);
        issue(16'h0010);
        wait_res("new_key", 10'h100, 1'b1, 16'h0010);

        bad_write("bad_stage7", 3'd7, 8'h10, 2'd1);
        bad_write("bad_idx3", 3'd0, 8'h00, 2'd3);
        bad_write("bad_node_addr", 3'd1, 8'h05, 2'd0);
        wr_en = 1'b1; wr_stage = 3'd4; wr_addr = 8'h40; wr_idx = 2'd2; wr_key = 16'h0000;
        step();
        wr_en = 1'b0;
        check("last_stage_write_no_err", 32'(err), 32'd0);
        issue(16'h0010);
        wait_res("post_writes", 10'h101, 1'b1, 16'h0010);
        check("cnt_after_five", cnt, 32'd5);

        sent = 0; got = 0; held = 1'b0;
        h_leaf = '0; h_data = '0; h_match = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            res_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                lookup_valid = 1'b1;
                lookup_data  = sv_data[sent];
            end else begin
                lookup_valid = 1'b0;
            end
            #1;
            if (res_valid) begin
                if (!res_ready) begin
                    check("stall_ready_low", 32'(lookup_ready), 32'd0);
                    if (held) begin
                        check("stall_hold_leaf", 32'(res_leaf), 32'(h_leaf));
                        check("stall_hold_data", 32'(res_data), 32'(h_data));
                        check("stall_hold_match", 32'(res_match), 32'(h_match));
                    end else begin
                        held = 1'b1; h_leaf = res_leaf; h_data = res_data; h_match = res_match;
                    end
                end else begin
                    check($sformatf("stream%0d_data", got), 32'(res_data), 32'(sv_data[got]));
                    check($sformatf("stream%0d_leaf", got), 32'(res_leaf), 32'(sv_leaf[got]));
                    check($sformatf("stream%0d_match", got), 32'(res_match), 32'(sv_match[got]));
                    got++;
                end
            end
            fire = lookup_valid && lookup_ready;
            step();
            if (fire) sent++;
        end
        lookup_valid = 1'b0;
        res_ready = 1'b1;
        check("stream_got", 32'(got), 32'd8);
        check("stream_sent", 32'(sent), 32'd8);
        check("stall_seen", 32'(held), 32'd1);
        repeat (6) step();
        check("stream_no_extra", 32'(res_valid), 32'd0);
        check("cnt_after_stream", cnt, 32'd13);

        lookup_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lookup_data = 16'h0010 + 16'(i);
            step();
        end
        lookup_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_cnt", cnt, 32'd0);
        check("midrst_ready", 32'(lookup_ready), 32'd1);
        step(); step();
        rst_n = 1'b1;
        sawv = 0;
        repeat (8) begin
            step();
            if (res_valid) sawv = 1;
        end
        check("midrst_flushed", 32'(sawv), 32'd0);
        issue(16'h0010);
        wait_res("midrst_keys_reset", 10'h000, 1'b0, 16'h0010);
        check("cnt_after_reset", cnt, 32'd1);

        s2_wr_en = 1'b1; s2_wr_stage = 1'b0; s2_wr_addr = 2'd0;
        s2_wr_idx = 2'd0; s2_wr_key = 16'h0100; step();
        s2_wr_idx = 2'd1; s2_wr_key = 16'h0200; step();
        s2_wr_idx = 2'd2; s2_wr_key = 16'h0300; step();
        s2_wr_en = 1'b0;
        check("s2_write_no_err", 32'(s2_err), 32'd0);
        s2_lookup("s2_lk0250", 16'h0250, 4'h8, 1'b0);
        s2_lookup("s2_lk0200", 16'h0200, 4'h8, 1'b1);
        s2_lookup("s2_lk0050", 16'h0050, 4'h0, 1'b0);
        check("s2_cnt", s2_cnt, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
